// File: rtl/tl_c_sink_pkg.sv
// Shared types and helpers for the TileLink channel C sink.
// Holds the C opcode encoding, the D ReleaseAck opcode, the sink FSM states
// and the beat-count helper used by the sink datapath.
package tl_c_sink_pkg;

  typedef enum logic [2:0] {
    PROBE_ACK      = 3'd4,
    PROBE_ACK_DATA = 3'd5,
    RELEASE        = 3'd6,
    RELEASE_DATA   = 3'd7
  } c_opcode_e;

  localparam logic [2:0] D_RELEASE_ACK = 3'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Number of beats a C message occupies. Only the data-carrying opcodes span
  // several beats; lg_beat is log2 of the beat width in bytes.
  function automatic int unsigned beats_of(input logic [2:0]  opcode,
                                           input int unsigned size,
                                           input int unsigned lg_beat);
    int unsigned beats;
    beats = 32'd1;
    if ((opcode == PROBE_ACK_DATA || opcode == RELEASE_DATA) && size > lg_beat)
      beats = 32'd1 << (size - lg_beat);
    return beats;
  endfunction

endpackage

// File: rtl/tl_c_sink_ack_slot.sv
// Single-entry ReleaseAck holding register for channel D.
// A set while the entry drains in the same cycle refills it, so back-to-back
// releases can be acknowledged without a bubble.
module tl_c_sink_ack_slot #(
  parameter int SOURCE_W = 3,
  parameter int SIZE_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set,
  input  logic [SOURCE_W-1:0] set_source,
  input  logic [SIZE_W-1:0]   set_size,
  input  logic                d_ready,
  output logic                d_valid,
  output logic [SOURCE_W-1:0] d_source,
  output logic [SIZE_W-1:0]   d_size
);

  // Slot-full flag plus captured release source/size.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid  <= 1'b0;
      d_source <= '0;
      d_size   <= '0;
    end else if (set) begin
      d_valid  <= 1'b1;
      d_source <= set_source;
      d_size   <= set_size;
    end else if (d_valid && d_ready) begin
      d_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/tl_c_sink.sv
// Manager-side TileLink channel C sink (ProbeAck, ProbeAckData, Release,
// ReleaseData). Data beats are passed straight through to the writeback port
// with per-beat addresses; probe completions pulse probe_done; releases are
// acknowledged on channel D through a single-entry ack slot.
// Optional feature: define TL_C_SINK_PROTOCOL_CHECK_EN to add the sticky
// proto_err output and its protocol checks.
module tl_c_sink
  import tl_c_sink_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 3,
  parameter int SIZE_W   = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                c_valid,
  output logic                c_ready,
  input  logic [2:0]          c_opcode,
  input  logic [2:0]          c_param,
  input  logic [SIZE_W-1:0]   c_size,
  input  logic [SOURCE_W-1:0] c_source,
  input  logic [ADDR_W-1:0]   c_address,
  input  logic [DATA_W-1:0]   c_data,
  input  logic                c_corrupt,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [ADDR_W-1:0]   wb_address,
  output logic [DATA_W-1:0]   wb_data,
  output logic                wb_corrupt,
  output logic                wb_last,
  output logic                wb_probe,
  output logic                probe_done,
  output logic [SOURCE_W-1:0] probe_source,
  output logic [2:0]          probe_param,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SOURCE_W-1:0] d_source
`ifdef TL_C_SINK_PROTOCOL_CHECK_EN
  ,
  output logic                proto_err
`endif
);

  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned LG_BEAT    = $clog2(BEAT_BYTES);
  // Counter indexes beats of the largest legal burst; FSM leaves BURST at the
  // terminal count, so it never wraps.
  localparam int CNT_W = (MAX_SIZE > int'(LG_BEAT)) ? (MAX_SIZE - int'(LG_BEAT)) : 1;

  state_e              state;
  logic [2:0]          lat_opcode;
  logic [2:0]          lat_param;
  logic [SIZE_W-1:0]   lat_size;
  logic [SOURCE_W-1:0] lat_source;
  logic [ADDR_W-1:0]   lat_address;
  logic [CNT_W-1:0]    lat_last;
  logic [CNT_W-1:0]    count;

  logic [CNT_W-1:0]    first_last;
  logic [2:0]          cur_opcode;
  logic [2:0]          cur_param;
  logic [SIZE_W-1:0]   cur_size;
  logic [SOURCE_W-1:0] cur_source;
  logic                is_last;
  logic                is_data;
  logic                is_release;
  logic                is_probe;
  logic                stall_ack;
  logic                fire;
  logic                ack_set;

  // Index of the final beat for a message starting this cycle.
  assign first_last = CNT_W'(beats_of(c_opcode, 32'(c_size), LG_BEAT) - 32'd1);

  // Select the header governing the current beat: live in IDLE, latched in BURST.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    cur_opcode = c_opcode;
    cur_param  = c_param;
    cur_size   = c_size;
    cur_source = c_source;
    is_last    = (first_last == '0);
    if (state == ST_BURST) begin
      cur_opcode = lat_opcode;
      cur_param  = lat_param;
      cur_size   = lat_size;
      cur_source = lat_source;
      is_last    = (count == lat_last);
    end
  end

  assign is_data    = (cur_opcode == PROBE_ACK_DATA) || (cur_opcode == RELEASE_DATA);
  assign is_release = (cur_opcode == RELEASE) || (cur_opcode == RELEASE_DATA);
  assign is_probe   = (cur_opcode == PROBE_ACK) || (cur_opcode == PROBE_ACK_DATA);

  // A release cannot finish while the ack slot is full and not draining.
  assign stall_ack  = is_last && is_release && d_valid && !d_ready;
  assign c_ready    = is_data ? (wb_ready && !stall_ack) : !stall_ack;
  assign fire       = c_valid && c_ready;
  assign ack_set    = fire && is_last && is_release;

  assign wb_valid   = c_valid && is_data && !stall_ack;
  assign wb_address = (state == ST_IDLE) ? c_address
                                         : lat_address + (ADDR_W'(count) << LG_BEAT);
  assign wb_data    = c_data;
  assign wb_corrupt = c_corrupt;
  assign wb_last    = is_last;
  assign wb_probe   = (cur_opcode == PROBE_ACK_DATA);
  assign d_opcode   = D_RELEASE_ACK;

  // Burst tracking FSM with header latch and registered probe completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      lat_opcode   <= '0;
      lat_param    <= '0;
      lat_size     <= '0;
      lat_source   <= '0;
      lat_address  <= '0;
      lat_last     <= '0;
      probe_done   <= 1'b0;
      probe_source <= '0;
      probe_param  <= '0;
    end else begin
      probe_done <= 1'b0;
      if (fire && is_last && is_probe) begin
        probe_done   <= 1'b1;
        probe_source <= cur_source;
        probe_param  <= cur_param;
      end
      case (state)
        ST_IDLE: begin
          if (fire) begin
            lat_opcode  <= c_opcode;
            lat_param   <= c_param;
            lat_size    <= c_size;
            lat_source  <= c_source;
            lat_address <= c_address;
            lat_last    <= first_last;
            if (is_last) begin
              count <= '0;
            end else begin
              count <= CNT_W'(1);
              state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (fire) begin
            if (is_last) begin
              count <= '0;
              state <= ST_IDLE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  tl_c_sink_ack_slot #(
    .SOURCE_W (SOURCE_W),
    .SIZE_W   (SIZE_W)
  ) u_ack_slot (
    .clock      (clock),
    .reset      (reset),
    .set        (ack_set),
    .set_source (cur_source),
    .set_size   (cur_size),
    .d_ready    (d_ready),
    .d_valid    (d_valid),
    .d_source   (d_source),
    .d_size     (d_size)
  );

`ifdef TL_C_SINK_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] align_mask;
  logic              beat_err;

  assign align_mask = ~({ADDR_W{1'b1}} << c_size);

  // Classify each accepted beat as legal or not; flow control is unaffected.
  always_comb begin
    beat_err = 1'b0;
    if (fire) begin
      if (c_opcode < 3'd4 || c_size > SIZE_W'(MAX_SIZE))
        beat_err = 1'b1;
      if (state == ST_IDLE && |(c_address & align_mask))
        beat_err = 1'b1;
      if (state == ST_BURST &&
          (c_opcode != lat_opcode || c_source != lat_source || c_size != lat_size))
        beat_err = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      proto_err <= 1'b0;
    else if (beat_err)
      proto_err <= 1'b1;
  end
`endif

endmodule

// File: doc/tl_c_sink.md
Name: tl_c_sink

Overview:
- Manager-side receiver for TileLink channel C, as driven by the hart 0 dcache: ProbeAck, ProbeAckData, Release, ReleaseData.
- Accepts C beats and tracks multi-beat data bursts.
- Forwards data beats to a writeback port with per-beat addresses.
- Signals probe completion, and returns ReleaseAck on channel D through a single-entry ack slot.
- Sits between the dcache C port and the L2/memory-side writeback path.

Parameters:
- ADDR_W, 32, C address width.
- DATA_W, 32, beat width in bits; beat bytes = DATA_W/8.
- SOURCE_W, 3, source ID width.
- SIZE_W, 4, log2 size field width.
- MAX_SIZE, 6, largest legal lg2 size (64 B line, 16 beats).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- c_valid  in  1  C beat valid.
- c_ready  out  1  C beat accepted when c_valid && c_ready.
- c_opcode  in  3  4=ProbeAck, 5=ProbeAckData, 6=Release, 7=ReleaseData.
- c_param  in  3  shrink/report param.
- c_size  in  SIZE_W  lg2 bytes.
- c_source  in  SOURCE_W  requester ID.
- c_address  in  ADDR_W  base address, size-aligned.
- c_data  in  DATA_W  beat data.
- c_corrupt  in  1  beat corrupt.
- wb_valid  out  1  writeback beat valid.
- wb_ready  in  1  writeback accept.
- wb_address  out  ADDR_W  beat address.
- wb_data  out  DATA_W  beat data.
- wb_corrupt  out  1  beat corrupt.
- wb_last  out  1  final beat of burst.
- wb_probe  out  1  beat belongs to ProbeAckData.
- probe_done  out  1  one-cycle pulse when a ProbeAck/ProbeAckData completes.
- probe_source  out  SOURCE_W  source of the completed probe ack.
- probe_param  out  3  param of the completed probe ack.
- d_valid  out  1  ReleaseAck valid.
- d_ready  in  1  D accept.
- d_opcode  out  3  constant 6 (ReleaseAck).
- d_size  out  SIZE_W  latched release size.
- d_source  out  SOURCE_W  latched release source.

Behaviour:
- Beat count:
  - Data opcodes (5, 7): beats = 1 if c_size <= log2(DATA_W/8), else 2^(c_size - log2(DATA_W/8)).
  - Non-data opcodes (4, 6): always 1 beat, regardless of size.
- FSM IDLE / BURST.
  - IDLE: first beat latches opcode, param, size, source, address; beat counter is cleared.
  - A multi-beat data transfer whose first beat is accepted moves to BURST.
  - BURST: counter increments on each accepted beat. The accept of beat beats-1 returns to IDLE.
  - Header fields on later beats are ignored; latched values are used.
- wb path:
  - Combinational pass-through of data beats: wb_valid = c_valid && data opcode && !stall_ack.
  - wb_address = latched base + counter*(DATA_W/8). In IDLE it is c_address.
  - Non-data beats never assert wb_valid.
- c_ready:
  - Data beats: wb_ready && !stall_ack.
  - Non-data beats: !stall_ack.
- stall_ack: asserted when the current beat is the last beat of a Release/ReleaseData and the ack slot is full and not draining (d_valid && !d_ready). Same-cycle drain+refill is allowed.
- Ack slot:
  - Set on accepting the last beat of opcode 6 or 7, capturing source and size.
  - Cleared on d_valid && d_ready.
  - d_valid is the slot-full flag (registered).
- probe_done: registered pulse the cycle after the final beat of opcode 4 or 5 is accepted, with the latched source and param.
- Reset values: state IDLE; counter 0; d_valid 0; probe_done 0; latched fields 0.
  - c_ready and wb_valid are combinational and follow their equations.
  - Reset mid-burst discards the burst and any pending ack.
- Counter width is clog2 of the max beat count. No wrap is possible because the FSM exits at the terminal count.

Optional Feature:
- Macro TL_C_SINK_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output proto_err (1 bit, reset 0), a sticky flag set on any of:
    - illegal opcode (<4);
    - c_size > MAX_SIZE;
    - address not aligned to size;
    - mid-burst opcode/source/size differing from the latched values.
  - Cleared only by reset. It does not alter flow control.
- Undefined: the port and checks are absent.

Decomposition:
- Package tl_c_sink_pkg:
  - C opcode enum (PROBE_ACK, PROBE_ACK_DATA, RELEASE, RELEASE_DATA);
  - D_RELEASE_ACK constant = 6;
  - FSM state enum;
  - function beats_of(opcode, size).
- One natural sub-module, tl_c_sink_ack_slot: the single-entry D ack register with set/clear/refill.

Test Plan:
- Release, size 6, source 3 (single beat), d_ready=1 → no wb beats; d_valid=1 next cycle with d_opcode=6, d_source=3, d_size=6; clears on accept.
- ReleaseData, size 6, address 0x8000_0040, 16 beats, wb_ready=1 → 16 wb beats at 0x…40 through 0x…7C; wb_last on beat 16 only; d_valid the cycle after beat 16.
- ProbeAckData, size 6, with wb_ready toggling 1/0 → c_ready follows wb_ready; wb_probe=1 on all beats; probe_done pulses once with the latched source/param; d_valid stays 0.
- Two back-to-back Releases with d_ready=0 → first sets the slot; second is stalled (c_ready=0) until d_ready=1, then accepted the same cycle the first ack drains.
- Reset asserted at beat 5 of a ReleaseData → d_valid=0, FSM IDLE, counter 0; the next ReleaseData restarts wb_address at its base.
- TL_C_SINK_PROTOCOL_CHECK_EN: source changed on beat 2 of a burst → proto_err=1 and stays set; the burst still completes with 16 beats.
